// File: rtl/clk_en_if.sv
// rtl/clk_en_if.sv - run/divisor control inputs and strobe/waveform outputs of clk_en_gen
interface clk_en_if #(
  parameter int NUM_CH = 4,
  parameter int DIV_W  = 16
);
  logic                    i_enable;
  logic [NUM_CH*DIV_W-1:0] i_div;
  logic [NUM_CH-1:0]       i_div_load;
  logic [NUM_CH-1:0]       o_tick;
  logic [NUM_CH-1:0]       o_toggle;
  logic                    o_locked;

  modport master (
    output i_enable, i_div, i_div_load,
    input  o_tick, o_toggle, o_locked
  );

  modport slave (
    input  i_enable, i_div, i_div_load,
    output o_tick, o_toggle, o_locked
  );
endinterface

// File: rtl/clk_en_gen.sv
// rtl/clk_en_gen.sv - multi-channel clock-enable generator with lock sequencer
// Divisor reloads are deferred to period boundaries so no period is ever truncated or stretched.
module clk_en_gen #(
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = 16,
  parameter int DEF_DIV     = 1,
  parameter int LOCK_CYCLES = 16
) (
  input  logic     i_clk,
  input  logic     i_reset_n,
  clk_en_if.slave  bus
);
  localparam int LC_W = $clog2(LOCK_CYCLES + 1);

  logic [LC_W-1:0]   r_lock_cnt;
  logic              r_locked;
  logic [DIV_W-1:0]  r_cnt  [NUM_CH];
  logic [DIV_W-1:0]  r_div  [NUM_CH];
  logic [DIV_W-1:0]  r_pend [NUM_CH];
  logic [NUM_CH-1:0] r_pend_vld;
  logic [NUM_CH-1:0] r_tick;
  logic [NUM_CH-1:0] r_toggle;

  logic              w_run;
  logic [NUM_CH-1:0] w_act;
  logic [NUM_CH-1:0] w_last;
  logic [NUM_CH-1:0] w_bnd;

  always_comb begin
    w_run  = r_locked & bus.i_enable;
    w_act  = '0;
    w_last = '0;
    w_bnd  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_act[c]  = w_run & (r_div[c] != '0);
      w_last[c] = (r_cnt[c] == r_div[c] - DIV_W'(1));
      // An idle channel is always at a boundary, so loads apply immediately.
      w_bnd[c]  = w_last[c] | ~w_act[c];
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_lock_cnt <= '0;
      r_locked   <= 1'b0;
      r_pend_vld <= '0;
      r_tick     <= '0;
      r_toggle   <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        r_cnt[c]  <= '0;
        r_div[c]  <= DIV_W'(DEF_DIV);
        r_pend[c] <= '0;
      end
    end else begin
      if (r_lock_cnt != LC_W'(LOCK_CYCLES))
        r_lock_cnt <= r_lock_cnt + LC_W'(1);
      if (r_lock_cnt == LC_W'(LOCK_CYCLES - 1))
        r_locked <= 1'b1;

      for (int c = 0; c < NUM_CH; c++) begin
        if (w_act[c]) begin
          r_cnt[c]    <= w_last[c] ? '0 : r_cnt[c] + DIV_W'(1);
          r_tick[c]   <= w_last[c];
          r_toggle[c] <= (r_cnt[c] < (r_div[c] >> 1));
        end else begin
          r_cnt[c]    <= '0;
          r_tick[c]   <= 1'b0;
          r_toggle[c] <= 1'b0;
        end

        if (bus.i_div_load[c]) begin
          if (w_bnd[c]) begin
            r_div[c]      <= bus.i_div[c*DIV_W +: DIV_W];
            r_pend_vld[c] <= 1'b0;
          end else begin
            r_pend[c]     <= bus.i_div[c*DIV_W +: DIV_W];
            r_pend_vld[c] <= 1'b1;
          end
        end else if (r_pend_vld[c] && w_bnd[c]) begin
          r_div[c]      <= r_pend[c];
          r_pend_vld[c] <= 1'b0;
        end
      end
    end
  end

  assign bus.o_tick   = r_tick;
  assign bus.o_toggle = r_toggle;
  assign bus.o_locked = r_locked;
endmodule

// File: tb/tb_clk_en_gen.sv
// tb/tb_clk_en_gen.sv - self-checking bench for clk_en_gen
module tb_clk_en_gen;
  localparam int NCH  = 4;
  localparam int DW   = 16;
  localparam int DEFD = 1;
  localparam int LCY  = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  clk_en_if #(.NUM_CH(NCH), .DIV_W(DW)) bus ();

  clk_en_gen #(.NUM_CH(NCH), .DIV_W(DW), .DEF_DIV(DEFD), .LOCK_CYCLES(LCY)) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  // Reference: elapsed cycles into the current period, divisor and latest pending load per channel.
  int         m_div  [NCH];
  int         m_pend [NCH];
  int         m_el   [NCH];
  bit         m_pv   [NCH];
  logic [NCH-1:0] m_tick   = '0;
  logic [NCH-1:0] m_tog    = '0;
  logic           m_locked = 1'b0;
  int             m_since  = 0;

  always @(posedge clk) begin : model
    bit run, act, bnd;
    int nd;
    if (!rst_n) begin
      m_tick = '0; m_tog = '0; m_locked = 1'b0; m_since = 0;
      for (int c = 0; c < NCH; c++) begin
        m_div[c] = DEFD; m_pend[c] = 0; m_el[c] = 0; m_pv[c] = 0;
      end
    end else begin
      run = m_locked && bus.i_enable;
      for (int c = 0; c < NCH; c++) begin
        act = run && (m_div[c] != 0);
        bnd = !act || (m_el[c] == m_div[c] - 1);
        m_tick[c] = act && (m_el[c] == m_div[c] - 1);
        m_tog[c]  = act && (m_el[c] < m_div[c] / 2);
        m_el[c]   = bnd ? 0 : m_el[c] + 1;
        nd = int'(bus.i_div[c*DW +: DW]);
        if (bus.i_div_load[c]) begin
          if (bnd) begin m_div[c] = nd; m_pv[c] = 0; end
          else     begin m_pend[c] = nd; m_pv[c] = 1; end
        end else if (m_pv[c] && bnd) begin
          m_div[c] = m_pend[c]; m_pv[c] = 0;
        end
      end
      if (m_since < LCY) m_since++;
      m_locked = (m_since >= LCY);
    end
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.i_enable = 1'b1; bus.i_div = '0; bus.i_div_load = '0;
    repeat (2) cyc();
    n_cmp++;
    if (bus.o_tick !== 4'h0 || bus.o_toggle !== 4'h0 || bus.o_locked !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state: tick=%b tog=%b lock=%b want 0000 0000 0", bus.o_tick, bus.o_toggle, bus.o_locked);
    end
    rst_n = 1'b1;
    for (int i = 1; i <= LCY + 2; i++) begin
      cyc();
      n_cmp++;
      if (bus.o_locked !== (i >= LCY)) begin
        n_bad++;
        $display("FAIL lock_latency edge %0d: lock=%b want %b", i, bus.o_locked, (i >= LCY));
      end
      if (i == LCY + 1) begin
        n_cmp++;
        if (bus.o_tick !== 4'hF || bus.o_toggle !== 4'h0) begin
          n_bad++;
          $display("FAIL first_tick_d1: tick=%b tog=%b want 1111 0000", bus.o_tick, bus.o_toggle);
        end
      end
      n_cmp++;
      if (bus.o_tick !== m_tick || bus.o_toggle !== m_tog || bus.o_locked !== m_locked) begin
        n_bad++;
        $display("FAIL reset_model edge %0d: tick=%b tog=%b lock=%b want %b %b %b", i,
                 bus.o_tick, bus.o_toggle, bus.o_locked, m_tick, m_tog, m_locked);
      end
    end
  endtask

  task automatic test_load_disabled();
    int first0, first1, t0, t1, h0, h1;
    first0 = -1; first1 = -1; t0 = 0; t1 = 0; h0 = 0; h1 = 0;
    bus.i_enable = 1'b0;
    cyc();
    bus.i_div[0*DW +: DW] = 16'd4;
    bus.i_div[1*DW +: DW] = 16'd5;
    bus.i_div_load = 4'b0011;
    cyc();
    bus.i_div_load = '0;
    bus.i_enable = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      cyc();
      if (bus.o_tick[0] && first0 < 0) first0 = k;
      if (bus.o_tick[1] && first1 < 0) first1 = k;
      t0 += int'(bus.o_tick[0]);   t1 += int'(bus.o_tick[1]);
      h0 += int'(bus.o_toggle[0]); h1 += int'(bus.o_toggle[1]);
      n_cmp++;
      if (bus.o_tick !== m_tick || bus.o_toggle !== m_tog || bus.o_locked !== m_locked) begin
        n_bad++;
        $display("FAIL load_disabled_model k=%0d: tick=%b tog=%b want %b %b", k, bus.o_tick, bus.o_toggle, m_tick, m_tog);
      end
    end
    n_cmp++;
    if (first0 != 4 || first1 != 5) begin
      n_bad++;
      $display("FAIL first_tick_latency: ch0=%0d ch1=%0d want 4 5", first0, first1);
    end
    n_cmp++;
    if (t0 != 5 || t1 != 4 || h0 != 10 || h1 != 8) begin
      n_bad++;
      $display("FAIL duty_counts: ticks %0d %0d highs %0d %0d want 5 4 10 8", t0, t1, h0, h1);
    end
  endtask

  task automatic test_retarget();
    int q[$];
    bus.i_enable = 1'b0;
    bus.i_div[0*DW +: DW] = 16'd8; bus.i_div_load = 4'b0001;
    cyc();
    bus.i_div_load = '0;
    bus.i_enable = 1'b1;
    for (int k = 1; k <= 26; k++) begin
      bus.i_div_load = '0;
      if (k == 3) begin bus.i_div[0*DW +: DW] = 16'd3; bus.i_div_load = 4'b0001; end
      if (k == 5) begin bus.i_div[0*DW +: DW] = 16'd6; bus.i_div_load = 4'b0001; end
      cyc();
      if (bus.o_tick[0]) q.push_back(k);
      n_cmp++;
      if (bus.o_tick !== m_tick || bus.o_toggle !== m_tog) begin
        n_bad++;
        $display("FAIL retarget_model k=%0d: tick=%b tog=%b want %b %b", k, bus.o_tick, bus.o_toggle, m_tick, m_tog);
      end
    end
    bus.i_div_load = '0;
    n_cmp++;
    if (q.size() != 4 || q[0] != 8 || q[1] != 14 || q[2] != 20 || q[3] != 26) begin
      n_bad++;
      $display("FAIL retarget_ticks: got %0d ticks first=%0d want 8,14,20,26", q.size(), (q.size() > 0) ? q[0] : -1);
    end
  endtask

  task automatic test_load_at_last();
    int q[$];
    bus.i_enable = 1'b0;
    bus.i_div[0*DW +: DW] = 16'd6; bus.i_div_load = 4'b0001;
    cyc();
    bus.i_div_load = '0;
    bus.i_enable = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      bus.i_div_load = '0;
      if (k == 12) begin bus.i_div[0*DW +: DW] = 16'd3; bus.i_div_load = 4'b0001; end
      cyc();
      if (bus.o_tick[0]) q.push_back(k);
      n_cmp++;
      if (bus.o_tick !== m_tick || bus.o_toggle !== m_tog) begin
        n_bad++;
        $display("FAIL at_last_model k=%0d: tick=%b tog=%b want %b %b", k, bus.o_tick, bus.o_toggle, m_tick, m_tog);
      end
    end
    bus.i_div_load = '0;
    n_cmp++;
    if (q.size() != 4 || q[0] != 6 || q[1] != 12 || q[2] != 15 || q[3] != 18) begin
      n_bad++;
      $display("FAIL at_last_ticks: got %0d ticks want 6,12,15,18", q.size());
    end
  endtask

  task automatic test_d_zero();
    int viol;
    viol = 0;
    bus.i_enable = 1'b0;
    for (int c = 0; c < NCH; c++)
      bus.i_div[c*DW +: DW] = (c == 2) ? 16'd0 : 16'($urandom_range(1, 7));
    bus.i_div_load = 4'b1111;
    cyc();
    bus.i_div_load = '0;
    bus.i_enable = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      cyc();
      if (bus.o_tick[2] !== 1'b0 || bus.o_toggle[2] !== 1'b0) viol++;
      n_cmp++;
      if (bus.o_tick !== m_tick || bus.o_toggle !== m_tog) begin
        n_bad++;
        $display("FAIL d_zero_model k=%0d: tick=%b tog=%b want %b %b", k, bus.o_tick, bus.o_toggle, m_tick, m_tog);
      end
    end
    n_cmp++;
    if (viol != 0) begin
      n_bad++;
      $display("FAIL d_zero_ch2: %0d active cycles want 0", viol);
    end
  endtask

  task automatic test_enable_reset();
    bus.i_enable = 1'b0;
    bus.i_div = {16'd2, 16'd3, 16'd6, 16'd4};
    bus.i_div_load = 4'b1111;
    cyc();
    bus.i_div_load = '0;
    bus.i_enable = 1'b1;
    repeat (7) cyc();
    bus.i_enable = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      cyc();
      n_cmp++;
      if (bus.o_tick !== 4'h0 || bus.o_toggle !== 4'h0) begin
        n_bad++;
        $display("FAIL enable_low k=%0d: tick=%b tog=%b want 0000 0000", k, bus.o_tick, bus.o_toggle);
      end
    end
    bus.i_enable = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      cyc();
      if (k == 12) begin
        n_cmp++;
        if (bus.o_tick !== 4'hF) begin
          n_bad++;
          $display("FAIL realign: tick=%b want 1111", bus.o_tick);
        end
      end
      n_cmp++;
      if (bus.o_tick !== m_tick || bus.o_toggle !== m_tog) begin
        n_bad++;
        $display("FAIL reenable_model k=%0d: tick=%b tog=%b want %b %b", k, bus.o_tick, bus.o_toggle, m_tick, m_tog);
      end
    end
    bus.i_div[0*DW +: DW] = 16'd7; bus.i_div_load = 4'b0001;
    rst_n = 1'b0;
    cyc();
    bus.i_div_load = '0;
    cyc();
    n_cmp++;
    if (bus.o_tick !== 4'h0 || bus.o_toggle !== 4'h0 || bus.o_locked !== 1'b0) begin
      n_bad++;
      $display("FAIL midrun_reset: tick=%b tog=%b lock=%b want 0000 0000 0", bus.o_tick, bus.o_toggle, bus.o_locked);
    end
    rst_n = 1'b1;
    repeat (LCY + 1) cyc();
    n_cmp++;
    if (bus.o_tick !== 4'hF || bus.o_toggle !== 4'h0 || bus.o_locked !== 1'b1) begin
      n_bad++;
      $display("FAIL default_div_after_reset: tick=%b tog=%b lock=%b want 1111 0000 1", bus.o_tick, bus.o_toggle, bus.o_locked);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      bus.i_enable = ($urandom_range(0, 19) != 0);
      for (int c = 0; c < NCH; c++) begin
        bus.i_div[c*DW +: DW] = 16'($urandom_range(0, 9));
        bus.i_div_load[c] = ($urandom_range(0, 5) == 0);
      end
      cyc();
      n_cmp++;
      if (bus.o_tick !== m_tick || bus.o_toggle !== m_tog || bus.o_locked !== m_locked) begin
        n_bad++;
        $display("FAIL random_model k=%0d: tick=%b tog=%b lock=%b want %b %b %b", k,
                 bus.o_tick, bus.o_toggle, bus.o_locked, m_tick, m_tog, m_locked);
      end
    end
    bus.i_div_load = '0;
  endtask

  initial begin
    bus.i_enable = 1'b0; bus.i_div = '0; bus.i_div_load = '0;
    test_reset();
    test_load_disabled();
    test_retarget();
    test_load_at_last();
    test_d_zero();
    test_enable_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/clk_en_gen.md
# clk_en_gen

Parametrised, multi-channel clock-enable generator for the fabric clock domain downstream of `clk_gen`. It derives `NUM_CH` independent divided strobes and duty-cycle waveforms from one clock, each with a runtime-reprogrammable divisor applied glitch-free at period boundaries. A built-in lock sequencer holds all outputs off for a fixed settling time after reset. Consumers use `o_tick` as a clock enable; no derived clocks are created.

## Interface
- `NUM_CH`, 4, number of channels (≥1)
- `DIV_W`, 16, divisor width per channel (≥2)
- `DEF_DIV`, 1, divisor loaded into every channel at reset (< 2^DIV_W)
- `LOCK_CYCLES`, 16, clock edges after reset release before `o_locked` asserts (≥1)

- `i_clk` in 1 — single clock; all logic on rising edge
- `i_reset_n` in 1 — synchronous, active-low reset
- `i_enable` in 1 — global run; low stops all channels and re-aligns them
- `i_div` in NUM_CH*DIV_W — divisor per channel; channel c at bits [c*DIV_W +: DIV_W]
- `i_div_load` in NUM_CH — per-channel one-cycle load strobe for `i_div` slice
- `o_tick` out NUM_CH — one-cycle strobe per period per channel
- `o_toggle` out NUM_CH — registered duty waveform, period D (fabric signal, never a clock)
- `o_locked` out 1 — settling complete; sticky until reset

## Operation
- Reset (`i_reset_n`=0 at an edge): `o_tick`=0, `o_toggle`=0, `o_locked`=0, every `cnt[c]`=0, `div[c]`=DEF_DIV, every `pend_vld[c]`=0, lock counter=0.
- Lock sequencer: lock counter increments each edge out of reset, saturates; `o_locked` registers 1 at the LOCK_CYCLES-th edge after reset release and stays 1.
- `run` = `o_locked` & `i_enable`. `act[c]` = `run` & (`div[c]` ≠ 0).
- Per channel at each edge, with D = `div[c]`, `last` = (`cnt[c]` == D−1):
  - `act[c]`: `cnt[c]` ← `last` ? 0 : `cnt[c]`+1; `o_tick[c]` ← `last`; `o_toggle[c]` ← (`cnt[c]` < D>>1).
  - not `act[c]`: `cnt[c]` ← 0; `o_tick[c]` ← 0; `o_toggle[c]` ← 0.
- Result: tick period D cycles; `o_toggle` high floor(D/2) cycles, low ceil(D/2) cycles per period, phase-aligned with `o_tick` (toggle rises the cycle after the tick cycle... i.e. both are registered from the same `cnt`).
- D=0: channel disabled (outputs 0). D=1: `o_tick` constantly 1 while running, `o_toggle` constantly 0.
- Divisor update, per channel, at an edge:
  - boundary = `last` | ~`act[c]`.
  - `i_div_load[c]` & boundary: `div[c]` ← slice directly; `pend_vld[c]` ← 0.
  - `i_div_load[c]` & ~boundary: `pend[c]` ← slice, `pend_vld[c]` ← 1 (a later load overwrites; latest wins).
  - `pend_vld[c]` & boundary & ~`i_div_load[c]`: `div[c]` ← `pend[c]`; `pend_vld[c]` ← 0.
  - New divisor takes effect with `cnt`=0 on the following cycle; the current period is never truncated or stretched.
- `i_enable` low (or not yet locked): all counters cleared; on re-enable all channels restart at `cnt`=0 together, so channels with related divisors are phase-aligned.
- Reset mid-operation overrides everything, including pending loads.

## Timing
- Enable edge E = first edge with `run`=1. Channel with D≥1: first `o_tick` high in the cycle after edge E+D−1 (D cycles after `run`).
- `o_locked` latency from reset release: LOCK_CYCLES edges.
- `i_enable` low at edge k: all `o_tick`/`o_toggle` 0 after edge k.
- Load-to-effect: ≤ D cycles (next boundary); immediate when channel idle or at `last`.
- No combinational path from any input to any output.

## Test plan
- Reset release, LOCK_CYCLES=16, `i_enable`=1, DEF_DIV=1 -> `o_locked` rises after edge 16; `o_tick`=all-ones from next cycle; `o_toggle`=0.
- Load D=4 ch0, D=5 ch1 while disabled, then enable -> ch0 tick every 4 cycles, toggle 2 high/2 low; ch1 tick every 5, toggle 2 high/3 low; first ticks 4 and 5 cycles after enable.
- Ch0 running D=8, load D=3 at `cnt`=2, then D=6 at `cnt`=4 -> period of 8 completes, next period is 6 (3 discarded), no short tick.
- Load at `last` cycle -> new divisor applies at that edge; subsequent period uses new value.
- D=0 on ch2 -> `o_tick[2]`=`o_toggle[2]`=0 forever; other channels unaffected.
- Drop `i_enable` for 3 cycles mid-period, then reset asserted mid-period -> outputs zero, channels restart aligned on re-enable; after reset `o_locked`=0 and divisors back to DEF_DIV.
